wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter placed between the bus masters and the address-decoding mux.
- Master 0 is the CPU. Master 1 is a second requester, such as a UART debug loader or DMA engine.
- Arbitration is round-robin, with the grant held for the whole CYC_O burst.
- A per-transfer watchdog aborts hung slave accesses, so no master can deadlock the bus.

Parameters:
WB_DATA_WIDTH, 32, data bus width
WB_ADDR_WIDTH, 32, address bus width
WB_SEL_WIDTH, 4, byte-select width
TIMEOUT_CYCLES, 255, wait cycles without slave ack before abort; 0 disables the watchdog
TIMEOUT_DATA, 32'hDEAD_BEEF, read data returned to the master on an aborted transfer

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
m0_addr_i / m1_addr_i  in  WB_ADDR_WIDTH  master address
m0_data_i / m1_data_i  in  WB_DATA_WIDTH  master write data
m0_we_i / m1_we_i  in  1  write enable
m0_sel_i / m1_sel_i  in  WB_SEL_WIDTH  byte selects
m0_stb_i / m1_stb_i  in  1  strobe
m0_cyc_i / m1_cyc_i  in  1  cycle request
m0_ack_o / m1_ack_o  out  1  ack to master
m0_data_o / m1_data_o  out  WB_DATA_WIDTH  read data to master
s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o  out  (widths as above)  slave-side bus
s_ack_i  in  1  slave ack
s_data_i  in  WB_DATA_WIDTH  slave read data
grant_o  out  2  one-hot current owner; 00 = idle
timeout_o  out  1  one-cycle pulse per aborted transfer

Behaviour:
- Clock is clk_i; reset rst_i is asynchronous, active-high.
- Reset values:
  - state = IDLE; last_owner = 1, so master 0 wins the first tie; timeout counter = 0.
  - All outputs 0, except read data, which is TIMEOUT_DATA-independent 0.
- States: IDLE, GRANT0, GRANT1, ABORT. State, last_owner, counter and the abort owner are registered. Bus routing is combinational from the registered state.
- IDLE:
  - Slave-side outputs 0; both master acks 0.
  - Only m0_cyc_i high -> GRANT0. Only m1_cyc_i high -> GRANT1.
  - Both high -> grant the master that is not last_owner.
  - Arbitration latency is 1 cycle: a request seen in IDLE is forwarded on the next edge.
- GRANTn:
  - All s_* outputs mirror master n inputs.
  - s_ack_i and s_data_i route to master n; the other master sees ack 0 and data 0.
  - grant_o = one-hot n.
  - If mn_cyc_i = 0: s_cyc_o and s_stb_o go low in the same cycle (combinational mirror), next state IDLE, last_owner <= n.
  - The other master's cyc is ignored until release. There is no preemption.
- Watchdog (TIMEOUT_CYCLES != 0):
  - Counter clears on grant entry, on s_ack_i, and whenever the owner's stb is low.
  - Otherwise it increments each cycle while owner cyc & stb & !s_ack_i.
  - When the counter equals TIMEOUT_CYCLES-1 and s_ack_i is still low, next state is ABORT.
- ABORT (exactly 1 cycle):
  - s_cyc_o = s_stb_o = 0.
  - Owner ack = 1 and owner data = TIMEOUT_DATA.
  - timeout_o = 1; counter cleared.
  - Next state: GRANTn (same owner) if that owner's cyc is still high, else IDLE with last_owner <= n.
- Simultaneous events:
  - s_ack_i arriving on the same cycle the counter hits the limit: ack wins, no abort.
  - Owner drops cyc on the same cycle as the limit: release wins, no abort.
- Pipelined/burst: the grant persists across multiple stb/ack pairs within one CYC; the counter restarts per transfer.
- Reset mid-transfer: immediate return to IDLE, all outputs deasserted asynchronously; the slave sees cyc drop.
- No combinational path from any master input to another master's outputs.

Test Plan:
1. Single master: m0 read of 0x100, slave acks 2 cycles after s_stb_o -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses with the slave data; grant_o=01; m1_ack_o stays 0.
2. Tie: m0 and m1 raise cyc on the same edge after reset -> m0 granted first (grant_o=01). After m0 drops cyc, IDLE for 1 cycle, then grant_o=10 while m1 still requests.
3. Round-robin fairness: both masters request continuously, each issuing 1 transfer per CYC, 6 releases -> grant sequence 0,1,0,1,0,1; no master granted twice consecutively.
4. Burst hold: m1 holds cyc for 4 stb/ack transfers while m0 requests -> grant_o stays 10 for all 4; m0 granted only after m1 cyc falls.
5. Timeout: TIMEOUT_CYCLES=8, slave never acks an m0 read -> after 8 wait cycles, ABORT for 1 cycle: s_cyc_o=0, m0_ack_o=1, m0_data_o=DEAD_BEEF, timeout_o pulses once. With m0 holding cyc, the grant returns to m0.
6. Race and reset: s_ack_i on the exact limit cycle -> no timeout_o, normal data returned. Asserting rst_i during GRANT1 -> grant_o=00 and s_cyc_o=0 without waiting for a clock edge; after reset release, the first tie goes to m0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter. Round-robin between masters, grant held
// for a whole CYC burst, and a per-transfer watchdog that aborts hung accesses.
module wb_arbiter #(
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,

  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic                     m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,

  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic                     m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,

  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic                     s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,

  output logic [1:0]               grant_o,
  output logic                     timeout_o
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

  state_t           state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_cyc, own_stb;

  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie the master that did not own the bus last wins.
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d = GRANT0;
          owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
          owner_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        // Release beats ack, ack beats the watchdog limit.
        if (!own_cyc) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          cnt_d        = '0;
        end else if (s_ack_i || !own_stb) begin
          cnt_d = '0;
        end else if (WDOG_EN) begin
          if (cnt_q == CNT_LIMIT) begin
            state_d = ABORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ABORT: begin
        cnt_d = '0;
        if (own_cyc) begin
          state_d = owner_q ? GRANT1 : GRANT0;
        end else begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
    end
  end

  // Routing is decoded from registered state only, so one master's inputs never
  // reach the other master's outputs.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    case (state_q)
      GRANT0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_stb_o   = m0_stb_i;
        s_cyc_o   = m0_cyc_i;
        m0_ack_o  = s_ack_i;
        m0_data_o = s_data_i;
        grant_o   = 2'b01;
      end
      GRANT1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_stb_o   = m1_stb_i;
        s_cyc_o   = m1_cyc_i;
        m1_ack_o  = s_ack_i;
        m1_data_o = s_data_i;
        grant_o   = 2'b10;
      end
      ABORT: begin
        timeout_o = 1'b1;
        grant_o   = owner_q ? 2'b10 : 2'b01;
        if (owner_q) begin
          m1_ack_o  = 1'b1;
          m1_data_o = TIMEOUT_DATA;
        end else begin
          m0_ack_o  = 1'b1;
          m0_data_o = TIMEOUT_DATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, hand-written corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_wb_arbiter;
  localparam int TO = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_0200;
  localparam logic [31:0] W0 = 32'hA0A0_0000, W1 = 32'hB1B1_0001;
  localparam logic [31:0] SD = 32'h1234_5678;
  localparam logic [3:0]  SEL0 = 4'hF, SEL1 = 4'h3;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0;
  logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_stb_i = 1'b0, m0_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic [31:0] s_addr_o, s_data_o;
  logic        s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic        s_ack_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_arbiter #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TDATA)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_data_i(s_data_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] pack(logic [1:0] g, logic to, logic cy, logic st, logic we,
                                        logic [3:0] sel, logic [31:0] ad, logic [31:0] wd,
                                        logic a0, logic a1, logic [31:0] d0, logic [31:0] d1);
    return {20'b0, g, to, cy, st, we, sel, ad, wd, a0, a1, d0, d1};
  endfunction

  // {rst,c0,s0,c1,s1,ack} | grant | {s_cyc,s_stb,ack0,ack1,timeout,data0 routed,data1 routed}
  typedef struct packed {
    logic [5:0] in;
    logic [1:0] g;
    logic [6:0] ex;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic [5:0] in, logic [1:0] g, logic [6:0] ex);
    vec_t r;
    r.in = in; r.g = g; r.ex = ex;
    return r;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Reference model state: owner -1 means bus free.
  int   m_owner, m_last, m_waits;
  bit   m_abort;

  initial begin
    logic o1;
    logic [1:0] og;
    logic cy, st, a0, a1, to, dr0, dr1;
    logic [31:0] ead, ewd;
    logic ewe;
    logic [3:0] esel;
    int hit;

    // Single-master read, slave acks two cycles after stb
    tbl.push_back(v(6'b0_11_00_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_11_00_0, 2'b01, 7'b11_00_0_10));
    tbl.push_back(v(6'b0_11_00_0, 2'b01, 7'b11_00_0_10));
    tbl.push_back(v(6'b0_11_00_1, 2'b01, 7'b11_10_0_10));
    tbl.push_back(v(6'b0_00_00_0, 2'b01, 7'b00_00_0_10));
    tbl.push_back(v(6'b0_00_00_0, 2'b00, 7'b00_00_0_00));
    // Tie after reset goes to m0, then m1 after one idle cycle
    tbl.push_back(v(6'b1_00_00_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_11_11_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_11_11_1, 2'b01, 7'b11_10_0_10));
    tbl.push_back(v(6'b0_00_11_0, 2'b01, 7'b00_00_0_10));
    tbl.push_back(v(6'b0_00_11_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_00_11_1, 2'b10, 7'b11_01_0_01));
    tbl.push_back(v(6'b0_00_00_0, 2'b10, 7'b00_00_0_01));
    // Round-robin: both keep requesting, one transfer per CYC, six releases
    for (int k = 0; k < 6; k++) begin
      o1 = (k % 2 == 1);
      og = o1 ? 2'b10 : 2'b01;
      tbl.push_back(v(6'b0_11_11_0, 2'b00, 7'b00_00_0_00));
      tbl.push_back(v(6'b0_11_11_1, og, {2'b11, !o1, o1, 1'b0, !o1, o1}));
      tbl.push_back(v({1'b0, o1, o1, !o1, !o1, 1'b0}, og, {4'b0000, 1'b0, !o1, o1}));
    end
    // Burst hold: m1 keeps the bus for 4 transfers while m0 waits
    tbl.push_back(v(6'b0_00_11_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_11_11_1, 2'b10, 7'b11_01_0_01));
    tbl.push_back(v(6'b0_11_10_0, 2'b10, 7'b10_00_0_01));
    tbl.push_back(v(6'b0_11_11_1, 2'b10, 7'b11_01_0_01));
    tbl.push_back(v(6'b0_11_11_1, 2'b10, 7'b11_01_0_01));
    tbl.push_back(v(6'b0_11_11_1, 2'b10, 7'b11_01_0_01));
    tbl.push_back(v(6'b0_11_00_0, 2'b10, 7'b00_00_0_01));
    tbl.push_back(v(6'b0_11_00_0, 2'b00, 7'b00_00_0_00));
    tbl.push_back(v(6'b0_11_00_1, 2'b01, 7'b11_10_0_10));
    tbl.push_back(v(6'b0_00_00_0, 2'b01, 7'b00_00_0_10));
    tbl.push_back(v(6'b0_00_00_0, 2'b00, 7'b00_00_0_00));

    m0_addr_i = A0; m0_data_i = W0; m0_we_i = 1'b0; m0_sel_i = SEL0;
    m1_addr_i = A1; m1_data_i = W1; m1_we_i = 1'b1; m1_sel_i = SEL1;
    s_data_i  = SD;

    @(negedge clk_i);
    check("reset", {20'b0, grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o,
                    s_data_o, m0_ack_o, m1_ack_o, m0_data_o, m1_data_o}, '0);

    foreach (tbl[i]) begin
      @(posedge clk_i);
      #1 {rst_i, m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = tbl[i].in;
      @(negedge clk_i);
      {cy, st, a0, a1, to, dr0, dr1} = tbl[i].ex;
      ewe = 1'b0; esel = '0; ead = '0; ewd = '0;
      if (tbl[i].g == 2'b01) begin ewe = 1'b0; esel = SEL0; ead = A0; ewd = W0; end
      if (tbl[i].g == 2'b10) begin ewe = 1'b1; esel = SEL1; ead = A1; ewd = W1; end
      check($sformatf("vec%0d", i),
            pack(grant_o, timeout_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
                 m0_ack_o, m1_ack_o, m0_data_o, m1_data_o),
            pack(tbl[i].g, to, cy, st, ewe, esel, ead, ewd, a0, a1,
                 dr0 ? SD : 32'h0, dr1 ? SD : 32'h0));
    end

    // Watchdog abort: slave never acks an m0 read
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    hit = -1;
    for (int n = 0; n < 20 && hit < 0; n++) begin
      @(negedge clk_i);
      if (timeout_o) begin
        hit = n;
        check("to_abort", {124'b0, m0_ack_o, s_cyc_o, s_stb_o, m1_ack_o, m0_data_o, m1_data_o},
              {124'b0, 1'b1, 1'b0, 1'b0, 1'b0, TDATA, 32'h0});
      end
      @(posedge clk_i);
      #1;
    end
    check("to_cycles", 192'(hit), 192'(9));
    @(negedge clk_i);
    check("to_regrant", {188'b0, grant_o, timeout_o, s_cyc_o}, {188'b0, 2'b01, 1'b0, 1'b1});

    // Ack on the limit cycle wins; release on the limit cycle wins
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int n = 0; n < 8; n++) begin @(posedge clk_i); #1; end
    s_ack_i = 1'b1; s_data_i = 32'h5A5A_1234;
    @(negedge clk_i);
    check("race_ack", {158'b0, m0_ack_o, timeout_o, m0_data_o}, {158'b0, 1'b1, 1'b0, 32'h5A5A_1234});
    @(posedge clk_i);
    #1 s_ack_i = 1'b0;
    @(negedge clk_i);
    check("race_noabort", {188'b0, grant_o, timeout_o, s_cyc_o}, {188'b0, 2'b01, 1'b0, 1'b1});
    for (int n = 0; n < 7; n++) begin @(posedge clk_i); #1; end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk_i);
    check("race_lim", {188'b0, grant_o, timeout_o, s_cyc_o}, {188'b0, 2'b01, 1'b0, 1'b0});
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("race_release", {189'b0, grant_o, timeout_o}, {189'b0, 2'b00, 1'b0});

    // Asynchronous reset during GRANT1
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("rst_pre", {190'b0, grant_o}, {190'b0, 2'b10});
    #2 rst_i = 1'b1;
    #1 check("rst_async", {188'b0, grant_o, s_cyc_o, m1_ack_o}, '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    s_ack_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("rst_tie", {190'b0, grant_o}, {190'b0, 2'b01});

    // Randomized run against the reference model
    do_reset();
    m_owner = -1; m_last = 1; m_waits = 0; m_abort = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic slow;
      logic cc[2], ss[2];
      logic [31:0] ed[2];
      logic ea[2];
      slow = ((c / 300) % 2 == 1);
      if (m0_cyc_i) m0_cyc_i = slow ? ($urandom_range(0, 63) != 0) : ($urandom_range(0, 7) != 0);
      else          m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = slow ? ($urandom_range(0, 63) != 0) : ($urandom_range(0, 7) != 0);
      else          m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i  = m0_cyc_i && (slow ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0));
      m1_stb_i  = m1_cyc_i && (slow ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0));
      s_ack_i   = slow ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      m0_addr_i = $urandom; m0_data_i = $urandom; m0_we_i = 1'($urandom); m0_sel_i = 4'($urandom);
      m1_addr_i = $urandom; m1_data_i = $urandom; m1_we_i = 1'($urandom); m1_sel_i = 4'($urandom);
      s_data_i  = $urandom;
      cc[0] = m0_cyc_i; cc[1] = m1_cyc_i; ss[0] = m0_stb_i; ss[1] = m1_stb_i;

      @(negedge clk_i);
      og = 2'b00; to = 1'b0; cy = 1'b0; st = 1'b0;
      ewe = 1'b0; esel = '0; ead = '0; ewd = '0;
      ea[0] = 1'b0; ea[1] = 1'b0; ed[0] = '0; ed[1] = '0;
      if (m_owner >= 0) begin
        og = (m_owner == 1) ? 2'b10 : 2'b01;
        if (m_abort) begin
          to = 1'b1;
          ea[m_owner] = 1'b1;
          ed[m_owner] = TDATA;
        end else begin
          cy = cc[m_owner]; st = ss[m_owner];
          ewe  = (m_owner == 1) ? m1_we_i   : m0_we_i;
          esel = (m_owner == 1) ? m1_sel_i  : m0_sel_i;
          ead  = (m_owner == 1) ? m1_addr_i : m0_addr_i;
          ewd  = (m_owner == 1) ? m1_data_i : m0_data_i;
          ea[m_owner] = s_ack_i;
          ed[m_owner] = s_data_i;
        end
      end
      check($sformatf("rand@%0d", c),
            pack(grant_o, timeout_o, s_cyc_o, s_stb_o,
                 m_abort ? 1'b0 : s_we_o, m_abort ? 4'h0 : s_sel_o,
                 m_abort ? 32'h0 : s_addr_o, m_abort ? 32'h0 : s_data_o,
                 m0_ack_o, m1_ack_o, m0_data_o, m1_data_o),
            pack(og, to, cy, st, ewe, esel, ead, ewd, ea[0], ea[1], ed[0], ed[1]));

      @(posedge clk_i);
      if (m_owner < 0) begin
        if (cc[0] && cc[1]) m_owner = 1 - m_last;
        else if (cc[0])     m_owner = 0;
        else if (cc[1])     m_owner = 1;
        m_waits = 0;
      end else if (m_abort) begin
        m_abort = 1'b0;
        if (!cc[m_owner]) begin m_last = m_owner; m_owner = -1; end
      end else if (!cc[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_waits = 0;
      end else if (s_ack_i || !ss[m_owner]) begin
        m_waits = 0;
      end else begin
        m_waits++;
        if (m_waits == TO) begin m_abort = 1'b1; m_waits = 0; end
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
